// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALUop classes, R-type function codes
// and the execute-stage FSM states.
package alu_pkg;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_ADD   = 3'b001;
    localparam logic [2:0] ALUOP_SLT   = 3'b010;
    localparam logic [2:0] ALUOP_SUB   = 3'b011;

    localparam logic [5:0] FUNCT_ADD = 6'b000000;
    localparam logic [5:0] FUNCT_SUB = 6'b000001;
    localparam logic [5:0] FUNCT_AND = 6'b000010;
    localparam logic [5:0] FUNCT_OR  = 6'b000011;
    localparam logic [5:0] FUNCT_XOR = 6'b000100;
    localparam logic [5:0] FUNCT_LSL = 6'b000101;
    localparam logic [5:0] FUNCT_LSR = 6'b000110;
    localparam logic [5:0] FUNCT_NOT = 6'b000111;
    localparam logic [5:0] FUNCT_MUL = 6'b001000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_execute_pipe_seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle for WIDTH cycles.
// done is asserted during the final iteration, with product already including that step.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CW-1:0]    cnt_q;
    logic             run_q;

    assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = run_q && (cnt_q == CW'(WIDTH - 1));
    assign product = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_execute_pipe.sv
// Registered MIPS execute stage with valid/ready handshakes and an iterative multiplier.
// Define ALU_OVERFLOW_EN to build the signed ADD/SUB overflow flag; otherwise it is tied 0.
module alu_execute_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   read_data_1,
    input  logic [WIDTH-1:0]   read_data_2,
    input  logic [WIDTH-1:0]   immediate,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic               alu_src,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   alu_result,
    output logic               zero,
    output logic               overflow,
    output logic               busy
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             zero_q;
    logic             busy_q;

    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_sum;
    logic [WIDTH-1:0] op_diff;
    logic [WIDTH-1:0] op_result;
    logic             accept;
    logic             out_xfer;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign op_b     = alu_src ? immediate : read_data_2;
    assign op_sum   = read_data_1 + op_b;
    assign op_diff  = read_data_1 - op_b;
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;
    assign is_mul   = (alu_op == ALUOP_W'(ALUOP_RTYPE)) && (funct == FUNCT_W'(FUNCT_MUL));

    // Single-cycle result; MUL yields 0 here because the multiplier supplies it later.
    always_comb begin
        op_result = '0;
        case (alu_op)
            ALUOP_W'(ALUOP_ADD): op_result = op_sum;
            ALUOP_W'(ALUOP_SUB): op_result = op_diff;
            ALUOP_W'(ALUOP_SLT): op_result = WIDTH'($signed(read_data_1) < $signed(op_b));
            ALUOP_W'(ALUOP_RTYPE): begin
                case (funct)
                    FUNCT_W'(FUNCT_ADD): op_result = op_sum;
                    FUNCT_W'(FUNCT_SUB): op_result = op_diff;
                    FUNCT_W'(FUNCT_AND): op_result = read_data_1 & op_b;
                    FUNCT_W'(FUNCT_OR):  op_result = read_data_1 | op_b;
                    FUNCT_W'(FUNCT_XOR): op_result = read_data_1 ^ op_b;
                    FUNCT_W'(FUNCT_LSL): op_result = read_data_1 << op_b[SHW-1:0];
                    FUNCT_W'(FUNCT_LSR): op_result = read_data_1 >> op_b[SHW-1:0];
                    FUNCT_W'(FUNCT_NOT): op_result = ~read_data_1;
                    default:             op_result = '0;
                endcase
            end
            default: op_result = '0;
        endcase
    end

    assign result_d = (state_q == MUL) ? mul_product : op_result;

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (read_data_1),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // A MUL acceptance never coincides with a pending result: in_ready guarantees
    // the previous one transfers on that same edge, so out_valid can simply drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && is_mul) begin
                        state_q     <= MUL;
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else if (accept) begin
                        result_q    <= result_d;
                        zero_q      <= (result_d == '0);
                        out_valid_q <= 1'b1;
                    end else if (out_xfer) begin
                        out_valid_q <= 1'b0;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        result_q    <= result_d;
                        zero_q      <= (result_d == '0);
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic op_ovf;
    logic ovf_q;
    logic sign_a;
    logic sign_b;

    assign sign_a = read_data_1[WIDTH-1];
    assign sign_b = op_b[WIDTH-1];

    always_comb begin
        op_ovf = 1'b0;
        if ((alu_op == ALUOP_W'(ALUOP_ADD)) ||
            ((alu_op == ALUOP_W'(ALUOP_RTYPE)) && (funct == FUNCT_W'(FUNCT_ADD)))) begin
            op_ovf = (sign_a == sign_b) && (op_sum[WIDTH-1] != sign_a);
        end else if ((alu_op == ALUOP_W'(ALUOP_SUB)) ||
                     ((alu_op == ALUOP_W'(ALUOP_RTYPE)) && (funct == FUNCT_W'(FUNCT_SUB)))) begin
            op_ovf = (sign_a != sign_b) && (op_diff[WIDTH-1] != sign_a);
        end
    end

    // Loaded on every acceptance, so a MUL clears it and it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= op_ovf;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign out_valid  = out_valid_q;
    assign alu_result = result_q;
    assign zero       = zero_q;
    assign busy       = busy_q;

endmodule

// File: doc/alu_execute_pipe.md
Name: alu_execute_pipe

Overview:
Parametrised, registered execute stage for the MIPS datapath. Replaces the purely combinational ALU path.
- Valid/ready handshakes on both input and output.
- Registered result and zero flag.
- Iterative multi-cycle multiplier; the stage stalls upstream while the multiplier runs.
- Sits between decode/register-read and memory stage.

Parameters:
WIDTH, 32, datapath width (power of two, >= 8)
FUNCT_W, 6, width of the R-type function field
ALUOP_W, 3, width of the ALUop field from control

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/control valid
in_ready  output  1  stage can accept this cycle
read_data_1  input  WIDTH  operand A (rs)
read_data_2  input  WIDTH  operand B (rt)
immediate  input  WIDTH  sign-extended immediate
funct  input  FUNCT_W  R-type function code
alu_op  input  ALUOP_W  operation class from control
alu_src  input  1  1: B = immediate, 0: B = read_data_2
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
alu_result  output  WIDTH  registered result
zero  output  1  registered (alu_result == 0)
overflow  output  1  signed overflow flag (see Optional Feature)
busy  output  1  multiplier iterating

Behaviour:
- Reset (async, rst_n low): state IDLE; out_valid, alu_result, zero, overflow, busy all 0; multiplier registers cleared. Reset mid-multiply aborts the operation and produces no output.
- Acceptance: a transfer occurs when in_valid && in_ready at a rising edge.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Output transfer: occurs when out_valid && out_ready.
- Operand B = alu_src ? immediate : read_data_2, captured at acceptance.
- alu_op decode:
  - 000: R-type, decode funct.
  - 001: ADD (address calculation).
  - 010: SLT signed, result 1 or 0, zero-extended.
  - 011: SUB (branch compare).
  - others: result 0.
- funct decode (alu_op = 000):
  - 000000 ADD; 000001 SUB; 000010 AND; 000011 OR; 000100 XOR.
  - 000101 LSL, 000110 LSR: shift A by B[$clog2(WIDTH)-1:0].
  - 000111 NOT A.
  - 001000 MUL: low WIDTH bits of A*B.
  - others: result 0.
- Arithmetic wraps modulo 2^WIDTH.
- Single-cycle ops: out_valid and result are registered on the acceptance edge, so latency is 1.
- MUL FSM:
  - IDLE -> MUL on acceptance; busy = 1.
  - Shift-add, one multiplier bit per cycle, with a counter from 0 to WIDTH-1.
  - On the WIDTH-th edge after acceptance: result registered, out_valid = 1, state -> IDLE, busy = 0.
  - in_ready is 0 throughout MUL.
- Hold: while out_valid && !out_ready, alu_result, zero and overflow are held stable.
- Simultaneous events: output transfer and new acceptance on the same edge → new result replaces the old one and out_valid stays 1.
- Output transfer with no new acceptance clears out_valid. alu_result keeps its last value.
- zero is always computed from the registered result value.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- Defined: overflow = signed overflow of ADD/SUB (including alu_op 001/011), registered with the result. It is 0 for all other ops.
- Undefined: overflow is tied to 0 and no overflow logic is synthesised.
- The port exists in both builds.

Decomposition:
- Package alu_pkg holds:
  - alu_op codes;
  - funct codes;
  - FSM state enum (IDLE, MUL).
- One sub-module, seq_multiplier:
  - inputs: start, a, b;
  - outputs: done, product;
  - contains the WIDTH-cycle shift-add iteration and counter.

Test Plan:
- ADD: A=7, read_data_2=5, funct=000000, alu_op=000, alu_src=0 → one cycle later out_valid=1, alu_result=12, zero=0.
- OR with immediate: A=6, imm=12, funct=000011, alu_src=1 → alu_result=14; NOT: A=15, funct=000111 → 0xFFFFFFF0.
- SLT and zero: A=19, B=12, alu_op=010 → alu_result=0, zero=1. Swapped operands → alu_result=1.
- MUL: A=13, imm=15, alu_src=1, funct=001000 → in_ready=0 and busy=1 for 32 cycles; then alu_result=195, out_valid=1. A second request presented during MUL is not accepted until IDLE.
- Backpressure: out_ready=0 for 5 cycles after SUB 9-9 → alu_result=0 and zero=1 held stable, in_ready=0. Release out_ready with a new op on the same edge → new result appears back-to-back.
- Reset: assert rst_n=0 at cycle 10 of a MUL → outputs 0 immediately. After release, in_ready=1 and no stale out_valid. With ALU_OVERFLOW_EN, 0x7FFFFFFF+1 → overflow=1.
